// File: rtl/spi_master_pkg.sv
`default_nettype none
// ============================================================================
// Module      : spi_master_pkg
// Description : Register offsets and field positions shared by the SPI master
//               APB register file and its software-visible map.
// Revision    : 1.0 - initial release
// ============================================================================
package spi_master_pkg;

    // Byte offsets of the APB-visible registers. Only bits [4:2] are decoded.
    localparam logic [4:0] SPI_CTRL_OFS   = 5'h00;
    localparam logic [4:0] SPI_CMD_OFS    = 5'h04;
    localparam logic [4:0] SPI_STATUS_OFS = 5'h08;
    localparam logic [4:0] SPI_TXLO_OFS   = 5'h0C;
    localparam logic [4:0] SPI_TXHI_OFS   = 5'h10;
    localparam logic [4:0] SPI_RXLO_OFS   = 5'h14;
    localparam logic [4:0] SPI_RXHI_OFS   = 5'h18;

    // CTRL fields
    localparam int CTRL_OE_BIT    = 0;
    localparam int CTRL_BC_LSB    = 1;
    localparam int CTRL_BC_MSB    = 3;
    localparam int CTRL_IRQEN_BIT = 8;

    // CMD fields
    localparam int CMD_START_BIT  = 0;

    // STATUS fields
    localparam int STAT_BUSY_BIT  = 0;
    localparam int STAT_DONE_BIT  = 1;
    localparam int STAT_OVR_BIT   = 2;

endpackage : spi_master_pkg
`default_nettype wire

// File: rtl/spi_master_apb_regs.sv
`default_nettype none
// ============================================================================
// Module      : spi_master_apb_regs
// Description : APB3 register file in front of the SPI master shift engine.
//               Holds configuration and the 64-bit TX word, issues the start
//               pulse, captures the RX word at end of frame and reports
//               busy/done/overrun status with a level interrupt.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_master_apb_regs
    import spi_master_pkg::*;
(
    input  logic        clk,
    input  logic        rst_b,
    // APB slave
    input  logic        psel,
    input  logic        penable,
    input  logic        pwrite,
    input  logic [4:0]  paddr,
    input  logic [31:0] pwdata,
    output logic [31:0] prdata,
    output logic        pready,
    output logic        pslverr,
    // Shift engine control
    output logic        reg_ctrl_oe,
    output logic [2:0]  reg_ctrl_bc,
    output logic [63:0] reg_ctrl_tx_data,
    output logic        reg_ctrl_tran,
    input  logic        ctrl_reg_busy,
    input  logic [63:0] ctrl_reg_rx_data,
    input  logic        ctrl_reg_rd_en,
    // Interrupt
    output logic        irq
);

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic        r_oe;
    logic [2:0]  r_bc;
    logic        r_irq_en;
    logic [63:0] r_tx;
    logic [63:0] r_rx;
    logic        r_done;
    logic        r_ovr;
    logic        r_start_pend;
    logic        r_tran;
    logic        r_cap_pend;
    logic        r_irq;

    // ------------------------------------------------------------------------
    // Bus decode
    // ------------------------------------------------------------------------
    logic [2:0]  w_idx;
    logic        w_access;
    logic        w_wr;
    logic        w_rd;
    logic        w_sel_ctrl;
    logic        w_sel_cmd;
    logic        w_sel_status;
    logic        w_sel_txlo;
    logic        w_sel_txhi;
    logic        w_sel_rxlo;
    logic        w_sel_rxhi;
    logic        w_sel_unmapped;
    logic        w_sel_cfg;
    logic        w_bsy;
    logic        w_cfg_wr_ok;
    logic        w_start_req;
    logic        w_start_ok;
    logic        w_clr_done;
    logic        w_clr_ovr;
    logic        w_done_nxt;
    logic        w_ovr_nxt;
    logic        w_unused_addr;

    assign w_idx          = paddr[4:2];
    assign w_access       = psel & penable;
    assign w_wr           = w_access & pwrite;
    assign w_rd           = w_access & ~pwrite;

    assign w_sel_ctrl     = (w_idx == SPI_CTRL_OFS[4:2]);
    assign w_sel_cmd      = (w_idx == SPI_CMD_OFS[4:2]);
    assign w_sel_status   = (w_idx == SPI_STATUS_OFS[4:2]);
    assign w_sel_txlo     = (w_idx == SPI_TXLO_OFS[4:2]);
    assign w_sel_txhi     = (w_idx == SPI_TXHI_OFS[4:2]);
    assign w_sel_rxlo     = (w_idx == SPI_RXLO_OFS[4:2]);
    assign w_sel_rxhi     = (w_idx == SPI_RXHI_OFS[4:2]);
    assign w_sel_unmapped = ~(w_sel_ctrl | w_sel_cmd | w_sel_status |
                              w_sel_txlo | w_sel_txhi | w_sel_rxlo | w_sel_rxhi);
    assign w_sel_cfg      = w_sel_ctrl | w_sel_txlo | w_sel_txhi;

    // Byte-lane bits of the address are not decoded.
    assign w_unused_addr  = ^paddr[1:0];

    // Busy covers the gap between the start pulse and the engine raising busy.
    assign w_bsy          = ctrl_reg_busy | r_start_pend;

    // Configuration is frozen while a frame is pending or in flight.
    assign w_cfg_wr_ok    = w_wr & w_sel_cfg & ~w_bsy;
    assign w_start_req    = w_wr & w_sel_cmd & pwdata[CMD_START_BIT];
    assign w_start_ok     = w_start_req & ~w_bsy;

    assign w_clr_done     = w_wr & w_sel_status & pwdata[STAT_DONE_BIT];
    assign w_clr_ovr      = w_wr & w_sel_status & pwdata[STAT_OVR_BIT];

    // Capture has priority over a W1C clear in the same cycle.
    assign w_done_nxt     = r_cap_pend ? 1'b1 : (w_clr_done ? 1'b0 : r_done);
    assign w_ovr_nxt      = (r_cap_pend & r_done) ? 1'b1 : (w_clr_ovr ? 1'b0 : r_ovr);

    // ------------------------------------------------------------------------
    // APB response
    // ------------------------------------------------------------------------
    assign pready  = 1'b1;
    assign pslverr = w_access & (w_sel_unmapped |
                                 (w_wr & w_sel_cfg & w_bsy) |
                                 (w_start_req & w_bsy));

    // Read mux; drives zero outside a read access phase.
    always_comb begin
        prdata = '0;
        if (w_rd) begin
            case (w_idx)
                SPI_CTRL_OFS[4:2]: begin
                    prdata[CTRL_OE_BIT]             = r_oe;
                    prdata[CTRL_BC_MSB:CTRL_BC_LSB] = r_bc;
                    prdata[CTRL_IRQEN_BIT]          = r_irq_en;
                end
                SPI_STATUS_OFS[4:2]: begin
                    prdata[STAT_BUSY_BIT] = w_bsy;
                    prdata[STAT_DONE_BIT] = r_done;
                    prdata[STAT_OVR_BIT]  = r_ovr;
                end
                SPI_TXLO_OFS[4:2]: prdata = r_tx[31:0];
                SPI_TXHI_OFS[4:2]: prdata = r_tx[63:32];
                SPI_RXLO_OFS[4:2]: prdata = r_rx[31:0];
                SPI_RXHI_OFS[4:2]: prdata = r_rx[63:32];
                default:           prdata = '0;
            endcase
        end
    end

    // Configuration and transmit word, writable only while idle.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_oe     <= 1'b0;
            r_bc     <= 3'd0;
            r_irq_en <= 1'b0;
            r_tx     <= '0;
        end else if (w_cfg_wr_ok) begin
            if (w_sel_ctrl) begin
                r_oe     <= pwdata[CTRL_OE_BIT];
                r_bc     <= pwdata[CTRL_BC_MSB:CTRL_BC_LSB];
                r_irq_en <= pwdata[CTRL_IRQEN_BIT];
            end
            if (w_sel_txlo) begin
                r_tx[31:0] <= pwdata;
            end
            if (w_sel_txhi) begin
                r_tx[63:32] <= pwdata;
            end
        end
    end

    // Start sequencing: one-cycle pulse plus a pending flag until the engine responds.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_tran       <= 1'b0;
            r_start_pend <= 1'b0;
        end else begin
            r_tran <= w_start_ok;
            if (w_start_ok) begin
                r_start_pend <= 1'b1;
            end else if (ctrl_reg_busy | ctrl_reg_rd_en) begin
                r_start_pend <= 1'b0;
            end
        end
    end

    // Receive capture one cycle after end-of-frame, with done/overrun tracking.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_cap_pend <= 1'b0;
            r_rx       <= '0;
            r_done     <= 1'b0;
            r_ovr      <= 1'b0;
        end else begin
            r_cap_pend <= ctrl_reg_rd_en;
            if (r_cap_pend) begin
                r_rx <= ctrl_reg_rx_data;
            end
            r_done <= w_done_nxt;
            r_ovr  <= w_ovr_nxt;
        end
    end

    // Level interrupt registered from the next-state DONE.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_irq <= 1'b0;
        end else begin
            r_irq <= w_done_nxt & r_irq_en;
        end
    end

    assign reg_ctrl_oe      = r_oe;
    assign reg_ctrl_bc      = r_bc;
    assign reg_ctrl_tx_data = r_tx;
    assign reg_ctrl_tran    = r_tran;
    assign irq              = r_irq;

endmodule : spi_master_apb_regs
`default_nettype wire

// File: tb/tb_spi_master_apb_regs.sv
`default_nettype none
// ============================================================================
// Module      : tb_spi_master_apb_regs
// Description : Self-checking bench for spi_master_apb_regs with a loopback
//               behavioural model of the SPI shift engine.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_master_apb_regs;

    logic        clk;
    logic        rst_b;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [4:0]  paddr;
    logic [31:0] pwdata;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;
    logic        reg_ctrl_oe;
    logic [2:0]  reg_ctrl_bc;
    logic [63:0] reg_ctrl_tx_data;
    logic        reg_ctrl_tran;
    logic        irq;

    // Engine model state
    logic        m_busy;
    logic        m_rd_en;
    logic [63:0] m_sh;
    logic [63:0] m_rx;
    int          m_cnt;
    int          n_frames;
    int          n_tran;

    int n_tests = 0;
    int n_fail  = 0;

    spi_master_apb_regs u_dut (
        .clk              (clk),
        .rst_b            (rst_b),
        .psel             (psel),
        .penable          (penable),
        .pwrite           (pwrite),
        .paddr            (paddr),
        .pwdata           (pwdata),
        .prdata           (prdata),
        .pready           (pready),
        .pslverr          (pslverr),
        .reg_ctrl_oe      (reg_ctrl_oe),
        .reg_ctrl_bc      (reg_ctrl_bc),
        .reg_ctrl_tx_data (reg_ctrl_tx_data),
        .reg_ctrl_tran    (reg_ctrl_tran),
        .ctrl_reg_busy    (m_busy),
        .ctrl_reg_rx_data (m_rx),
        .ctrl_reg_rd_en   (m_rd_en),
        .irq              (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Loopback shift engine: sdi tied to sdo, MSB first, rx cleared at start.
    always @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            m_busy   <= 1'b0;
            m_rd_en  <= 1'b0;
            m_sh     <= '0;
            m_rx     <= '0;
            m_cnt    <= 0;
        end else begin
            m_rd_en <= 1'b0;
            if (reg_ctrl_tran && !m_busy) begin
                m_busy <= 1'b1;
                m_sh   <= reg_ctrl_tx_data;
                m_rx   <= '0;
                m_cnt  <= (int'(reg_ctrl_bc) + 1) * 8;
            end else if (m_busy) begin
                m_rx  <= {m_rx[62:0], m_sh[63]};
                m_sh  <= {m_sh[62:0], 1'b0};
                m_cnt <= m_cnt - 1;
                if (m_cnt == 1) begin
                    m_busy   <= 1'b0;
                    m_rd_en  <= 1'b1;
                    n_frames <= n_frames + 1;
                end
            end
        end
    end

    // Counts clock cycles during which the start pulse is high.
    always @(posedge clk) begin
        if (reg_ctrl_tran) n_tran <= n_tran + 1;
    end

    typedef struct {
        string       name;
        logic        wr;
        logic [4:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // One APB transfer; called just after a negedge, returns just after a negedge.
    task automatic apb(input logic wr, input logic [4:0] addr, input logic [31:0] wd,
                       output logic [31:0] rd, output logic err);
        psel    = 1'b1;
        penable = 1'b0;
        pwrite  = wr;
        paddr   = addr;
        pwdata  = wd;
        @(posedge clk);
        @(negedge clk);
        penable = 1'b1;
        #1;
        rd  = prdata;
        err = pslverr;
        @(posedge clk);
        @(negedge clk);
        psel    = 1'b0;
        penable = 1'b0;
        pwrite  = 1'b0;
    endtask

    task automatic wr_chk(input string name, input logic [4:0] addr, input logic [31:0] wd,
                          input logic exp_err);
        logic [31:0] rd;
        logic        err;
        apb(1'b1, addr, wd, rd, err);
        check(name, {63'd0, err}, {63'd0, exp_err});
    endtask

    task automatic rd_chk(input string name, input logic [4:0] addr, input logic [31:0] exp);
        logic [31:0] rd;
        logic        err;
        apb(1'b0, addr, 32'd0, rd, err);
        check(name, {32'd0, rd}, {32'd0, exp});
    endtask

    // Waits for the model's next end-of-frame, then lets capture and irq settle.
    task automatic wait_frame(input string name);
        int  start;
        bit  seen;
        start = n_frames;
        seen  = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (n_frames != start) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s: frame did not complete, got timeout expected rd_en", name);
        end
        repeat (3) @(negedge clk);
    endtask

    initial begin
        logic [31:0] rd;
        logic        err;
        int          tran0;
        bit          seen;

        n_frames = 0;
        n_tran   = 0;
        psel     = 1'b0;
        penable  = 1'b0;
        pwrite   = 1'b0;
        paddr    = '0;
        pwdata   = '0;
        rst_b    = 1'b0;
        repeat (3) @(negedge clk);

        // Reset-state outputs while still in reset
        check("rst_pready",  {63'd0, pready},   64'd1);
        check("rst_irq",     {63'd0, irq},      64'd0);
        check("rst_tx_data", reg_ctrl_tx_data,  64'd0);
        check("rst_tran",    {63'd0, reg_ctrl_tran}, 64'd0);
        rst_b = 1'b1;
        @(negedge clk);

        // Directed register vectors
        vecs.push_back('{"rd_ctrl_rst",   1'b0, 5'h00, 32'h0,        32'h0,        1'b0});
        vecs.push_back('{"rd_cmd_rst",    1'b0, 5'h04, 32'h0,        32'h0,        1'b0});
        vecs.push_back('{"rd_status_rst", 1'b0, 5'h08, 32'h0,        32'h0,        1'b0});
        vecs.push_back('{"rd_txlo_rst",   1'b0, 5'h0C, 32'h0,        32'h0,        1'b0});
        vecs.push_back('{"rd_txhi_rst",   1'b0, 5'h10, 32'h0,        32'h0,        1'b0});
        vecs.push_back('{"rd_rxlo_rst",   1'b0, 5'h14, 32'h0,        32'h0,        1'b0});
        vecs.push_back('{"rd_rxhi_rst",   1'b0, 5'h18, 32'h0,        32'h0,        1'b0});
        vecs.push_back('{"rd_unmap_rst",  1'b0, 5'h1C, 32'h0,        32'h0,        1'b1});
        vecs.push_back('{"wr_ctrl_all",   1'b1, 5'h00, 32'hFFFFFFFF, 32'h0,        1'b0});
        vecs.push_back('{"rd_ctrl_mask",  1'b0, 5'h00, 32'h0,        32'h0000010F, 1'b0});
        vecs.push_back('{"wr_txlo",       1'b1, 5'h0C, 32'h13579BDF, 32'h0,        1'b0});
        vecs.push_back('{"rd_txlo",       1'b0, 5'h0C, 32'h0,        32'h13579BDF, 1'b0});
        vecs.push_back('{"wr_txhi",       1'b1, 5'h10, 32'h2468ACE0, 32'h0,        1'b0});
        vecs.push_back('{"rd_txhi",       1'b0, 5'h10, 32'h0,        32'h2468ACE0, 1'b0});
        vecs.push_back('{"wr_rxlo_ro",    1'b1, 5'h14, 32'hFFFFFFFF, 32'h0,        1'b0});
        vecs.push_back('{"rd_rxlo_ro",    1'b0, 5'h14, 32'h0,        32'h0,        1'b0});
        vecs.push_back('{"wr_rxhi_ro",    1'b1, 5'h18, 32'hFFFFFFFF, 32'h0,        1'b0});
        vecs.push_back('{"rd_rxhi_ro",    1'b0, 5'h18, 32'h0,        32'h0,        1'b0});
        vecs.push_back('{"wr_status_w1c", 1'b1, 5'h08, 32'h00000007, 32'h0,        1'b0});
        vecs.push_back('{"rd_status_idle",1'b0, 5'h08, 32'h0,        32'h0,        1'b0});
        vecs.push_back('{"wr_cmd_nop",    1'b1, 5'h04, 32'h00000000, 32'h0,        1'b0});
        vecs.push_back('{"rd_cmd_wo",     1'b0, 5'h04, 32'h0,        32'h0,        1'b0});
        vecs.push_back('{"wr_unmap",      1'b1, 5'h1C, 32'h00000001, 32'h0,        1'b1});
        vecs.push_back('{"wr_ctrl_zero",  1'b1, 5'h00, 32'h00000000, 32'h0,        1'b0});
        vecs.push_back('{"rd_ctrl_zero",  1'b0, 5'h00, 32'h0,        32'h0,        1'b0});

        for (int i = 0; i < vecs.size(); i++) begin
            apb(vecs[i].wr, vecs[i].addr, vecs[i].wdata, rd, err);
            check({vecs[i].name, "_err"}, {63'd0, err}, {63'd0, vecs[i].exp_err});
            if (!vecs[i].wr)
                check({vecs[i].name, "_data"}, {32'd0, rd}, {32'd0, vecs[i].exp_rdata});
        end
        check("tx_out_after_wr", reg_ctrl_tx_data, 64'h2468ACE0_13579BDF);
        check("no_tran_yet",     n_tran,           0);

        // 8-bit loopback frame
        wr_chk("f8_ctrl",  5'h00, 32'h00000101, 1'b0);
        wr_chk("f8_txhi",  5'h10, 32'hA5000000, 1'b0);
        wr_chk("f8_txlo",  5'h0C, 32'h00000000, 1'b0);
        check("f8_oe", {63'd0, reg_ctrl_oe}, 64'd1);
        check("f8_bc", {61'd0, reg_ctrl_bc}, 64'd0);
        tran0 = n_tran;
        wr_chk("f8_cmd",   5'h04, 32'h00000001, 1'b0);
        rd_chk("f8_busy",  5'h08, 32'h00000001);
        wait_frame("f8_frame");
        check("f8_one_tran", n_tran - tran0, 1);
        rd_chk("f8_rxlo",   5'h14, 32'h000000A5);
        rd_chk("f8_status", 5'h08, 32'h00000002);
        check("f8_irq", {63'd0, irq}, 64'd1);
        wr_chk("f8_clr_done", 5'h08, 32'h00000002, 1'b0);
        @(negedge clk);
        check("f8_irq_clr", {63'd0, irq}, 64'd0);
        rd_chk("f8_status_clr", 5'h08, 32'h00000000);

        // 64-bit loopback frame
        wr_chk("f64_ctrl", 5'h00, 32'h0000010F, 1'b0);
        wr_chk("f64_txhi", 5'h10, 32'h01234567, 1'b0);
        wr_chk("f64_txlo", 5'h0C, 32'h89ABCDEF, 1'b0);
        check("f64_bc", {61'd0, reg_ctrl_bc}, 64'd7);
        wr_chk("f64_cmd",  5'h04, 32'h00000001, 1'b0);
        wait_frame("f64_frame");
        rd_chk("f64_rxhi",   5'h18, 32'h01234567);
        rd_chk("f64_rxlo",   5'h14, 32'h89ABCDEF);
        rd_chk("f64_status", 5'h08, 32'h00000002);
        wr_chk("f64_clr",    5'h08, 32'h00000002, 1'b0);

        // Busy protection during a 32-bit frame
        wr_chk("bp_ctrl", 5'h00, 32'h00000107, 1'b0);
        wr_chk("bp_txhi", 5'h10, 32'hDEADBEEF, 1'b0);
        wr_chk("bp_txlo", 5'h0C, 32'h12345678, 1'b0);
        tran0 = n_tran;
        wr_chk("bp_cmd",       5'h04, 32'h00000001, 1'b0);
        wr_chk("bp_txlo_busy", 5'h0C, 32'hFFFFFFFF, 1'b1);
        wr_chk("bp_cmd_busy",  5'h04, 32'h00000001, 1'b1);
        wr_chk("bp_ctrl_busy", 5'h00, 32'h00000000, 1'b1);
        rd_chk("bp_txlo_kept", 5'h0C, 32'h12345678);
        rd_chk("bp_ctrl_kept", 5'h00, 32'h00000107);
        wait_frame("bp_frame");
        check("bp_one_tran", n_tran - tran0, 1);
        rd_chk("bp_rxlo",   5'h14, 32'hDEADBEEF);
        rd_chk("bp_status", 5'h08, 32'h00000002);

        // Overrun: second frame with DONE still set
        wr_chk("ov_txhi", 5'h10, 32'hCAFEF00D, 1'b0);
        wr_chk("ov_cmd",  5'h04, 32'h00000001, 1'b0);
        wait_frame("ov_frame");
        rd_chk("ov_status", 5'h08, 32'h00000006);
        rd_chk("ov_rxlo",   5'h14, 32'hCAFEF00D);
        rd_chk("ov_rxhi",   5'h18, 32'h00000000);
        wr_chk("ov_clr",    5'h08, 32'h00000006, 1'b0);
        rd_chk("ov_status_clr", 5'h08, 32'h00000000);

        // W1C of DONE landing on the capture edge: the set must win
        wr_chk("sw_cmd", 5'h04, 32'h00000001, 1'b0);
        seen = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            if (m_rd_en) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("sw_rd_en_seen", {63'd0, seen}, 64'd1);
        apb(1'b1, 5'h08, 32'h00000002, rd, err);
        check("sw_clr_err", {63'd0, err}, 64'd0);
        @(negedge clk);
        rd_chk("sw_done_wins", 5'h08, 32'h00000002);
        check("sw_irq", {63'd0, irq}, 64'd1);

        // Reset asserted halfway through a 32-bit frame
        wr_chk("rm_clr",  5'h08, 32'h00000006, 1'b0);
        wr_chk("rm_txhi", 5'h10, 32'h55AA55AA, 1'b0);
        wr_chk("rm_cmd",  5'h04, 32'h00000001, 1'b0);
        repeat (14) @(negedge clk);
        check("rm_mid_busy", {63'd0, m_busy}, 64'd1);
        rst_b = 1'b0;
        #1;
        check("rm_oe",    {63'd0, reg_ctrl_oe},   64'd0);
        check("rm_bc",    {61'd0, reg_ctrl_bc},   64'd0);
        check("rm_tx",    reg_ctrl_tx_data,       64'd0);
        check("rm_tran",  {63'd0, reg_ctrl_tran}, 64'd0);
        check("rm_irq",   {63'd0, irq},           64'd0);
        check("rm_prdata",{32'd0, prdata},        64'd0);
        check("rm_err",   {63'd0, pslverr},       64'd0);
        @(negedge clk);
        rst_b = 1'b1;
        repeat (40) @(negedge clk);
        check("rm_engine_idle", {63'd0, m_busy}, 64'd0);
        rd_chk("rm_status", 5'h08, 32'h00000000);
        rd_chk("rm_rxlo",   5'h14, 32'h00000000);
        check("rm_irq_after", {63'd0, irq}, 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_spi_master_apb_regs
`default_nettype wire
